multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V style control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Memory waits in FETCH and MEM are bounded by MEM_TIMEOUT; an expired wait
// parks the FSM in ERR until reset.
// Optional build macro: ILLEGAL_TRAP_EN (unsupported opcodes trap to ERR
// instead of retiring as a NOP).
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic [1:0] imm_sel,
  output logic       alu_src,
  output logic       reg_we,
  output logic       mem_to_reg,
  output logic       err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Last count value at which a completing mem_ready is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [7:0] cnt_q, cnt_d;

  logic is_load, is_store, is_opimm, is_rtype, is_branch, is_legal;

  // Immediate format selected by the latched opcode (R-type and unknown: none).
  function automatic logic [1:0] imm_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_OPIMM: imm_fmt = 2'd1;
      OP_STORE:          imm_fmt = 2'd2;
      OP_BRANCH:         imm_fmt = 2'd3;
      default:           imm_fmt = 2'd0;
    endcase
  endfunction

  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_opimm  = (op_q == OP_OPIMM);
  assign is_rtype  = (op_q == OP_RTYPE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_legal  = is_load | is_store | is_opimm | is_rtype | is_branch;

  // State, latched opcode and wait counter; reset abandons any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control outputs; all outputs are held low while reset is high.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    imm_sel    = 2'd0;
    alu_src    = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    err        = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            op_d    = opcode;
            state_d = DECODE;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DECODE: begin
          imm_sel = imm_fmt(op_q);
          if (is_legal) begin
            state_d = EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_d = ERR;
`else
            // Unknown opcode retires as a NOP: step the PC and refetch.
            pc_we   = 1'b1;
            state_d = FETCH;
`endif
          end
        end
        EXEC: begin
          imm_sel = imm_fmt(op_q);
          alu_src = is_load | is_store | is_opimm;
          if (is_branch) begin
            pc_we   = 1'b1;
            pc_sel  = br_taken;
            state_d = FETCH;
          end else if (is_load || is_store) begin
            state_d = MEM;
          end else begin
            state_d = WB;
          end
        end
        MEM: begin
          imm_sel = imm_fmt(op_q);
          mem_rd  = is_load;
          mem_wr  = is_store;
          if (mem_ready) begin
            if (is_load) begin
              state_d = WB;
            end else begin
              pc_we   = 1'b1;
              state_d = FETCH;
            end
          end else if (cnt_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        WB: begin
          reg_we     = 1'b1;
          mem_to_reg = is_load;
          pc_we      = 1'b1;
          state_d    = FETCH;
        end
        ERR: begin
          err = 1'b1;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (built with MEM_TIMEOUT=4).
// Output vector layout:
// {mem_rd, mem_wr, ir_we, pc_we, pc_sel, imm_sel[1:0], alu_src, reg_we, mem_to_reg, err}
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  localparam logic [10:0] O_IDLE   = 11'b0_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] O_FETCH  = 11'b1_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] O_IR     = 11'b1_0_1_0_0_00_0_0_0_0;
  localparam logic [10:0] O_WB_ALU = 11'b0_0_0_1_0_00_0_1_0_0;
  localparam logic [10:0] O_WB_LD  = 11'b0_0_0_1_0_00_0_1_1_0;
  localparam logic [10:0] O_ERR    = 11'b0_0_0_0_0_00_0_0_0_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       br_taken;
  logic       mem_rd, mem_wr, ir_we, pc_we, pc_sel;
  logic [1:0] imm_sel;
  logic       alu_src, reg_we, mem_to_reg, err;
  logic [10:0] outv;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic        br;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .br_taken   (br_taken),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .imm_sel    (imm_sel),
    .alu_src    (alu_src),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .err        (err)
  );

  assign outv = {mem_rd, mem_wr, ir_we, pc_we, pc_sel, imm_sel, alu_src, reg_we, mem_to_reg, err};

  task automatic add(input logic r, input logic [6:0] op, input logic rdy,
                     input logic br, input logic [10:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.br = br; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input logic [10:0] exp, input string nm);
    n_tests++;
    if (outv !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b, expected %b", nm, outv, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input logic r, input logic [6:0] op, input logic rdy,
                      input logic br, input logic [10:0] exp, input string nm);
    reset = r; opcode = op; mem_ready = rdy; br_taken = br;
    #2;
    check(exp, nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then release into FETCH with one wait cycle
    add(1, 7'd0, 0, 0, O_IDLE);
    add(0, 7'd0, 0, 0, O_FETCH);
    // R-type: ir_we cycle 1, reg_we+pc_we cycle 4
    add(0, OP_RTYPE, 1, 0, O_IR);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_00_0_0_0_0);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_00_0_0_0_0);
    add(0, 7'd0, 1, 0, O_WB_ALU);
    // OP-IMM
    add(0, OP_OPIMM, 1, 0, O_IR);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_01_0_0_0_0);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_01_1_0_0_0);
    add(0, 7'd0, 1, 0, O_WB_ALU);
    // Load, data ready on 4th MEM cycle (count = MEM_TIMEOUT-1 boundary)
    add(0, OP_LOAD, 1, 0, O_IR);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_01_0_0_0_0);
    add(0, 7'd0, 0, 0, 11'b0_0_0_0_0_01_1_0_0_0);
    add(0, 7'd0, 0, 0, 11'b1_0_0_0_0_01_0_0_0_0);
    add(0, 7'd0, 0, 0, 11'b1_0_0_0_0_01_0_0_0_0);
    add(0, 7'd0, 0, 0, 11'b1_0_0_0_0_01_0_0_0_0);
    add(0, 7'd0, 1, 0, 11'b1_0_0_0_0_01_0_0_0_0);
    add(0, 7'd0, 1, 0, O_WB_LD);
    // Store, ready at once
    add(0, OP_STORE, 1, 0, O_IR);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_10_0_0_0_0);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_10_1_0_0_0);
    add(0, 7'd0, 1, 0, 11'b0_1_0_1_0_10_0_0_0_0);
    // Branch taken, then not taken
    add(0, OP_BRANCH, 1, 0, O_IR);
    add(0, 7'd0, 1, 0, 11'b0_0_0_0_0_11_0_0_0_0);
    add(0, 7'd0, 1, 1, 11'b0_0_0_1_1_11_0_0_0_0);
    add(0, OP_BRANCH, 1, 0, O_IR);
    add(0, 7'd0, 1, 1, 11'b0_0_0_0_0_11_0_0_0_0);
    add(0, 7'd0, 1, 0, 11'b0_0_0_1_0_11_0_0_0_0);
    // Unsupported opcode, then a fetch that never completes
    add(0, OP_BAD, 1, 0, O_IR);
`ifdef ILLEGAL_TRAP_EN
    add(0, 7'd0, 0, 0, O_IDLE);
    for (int i = 0; i < 4; i++) add(0, 7'd0, 0, 0, O_ERR);
`else
    add(0, 7'd0, 0, 0, 11'b0_0_0_1_0_00_0_0_0_0);
    for (int i = 0; i < 4; i++) add(0, 7'd0, 0, 0, O_FETCH);
`endif
    add(0, 7'd0, 1, 0, O_ERR);
    add(0, OP_RTYPE, 1, 0, O_ERR);
    add(1, 7'd0, 0, 0, O_IDLE);
    add(0, 7'd0, 0, 0, O_FETCH);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].br, tbl[i].exp, $sformatf("row%0d", i));

    // Reset asserted mid-cycle during store MEM: mem_wr must drop at once.
    step(0, OP_STORE, 1, 0, O_IR, "st_fetch");
    step(0, 7'd0, 1, 0, 11'b0_0_0_0_0_10_0_0_0_0, "st_decode");
    step(0, 7'd0, 0, 0, 11'b0_0_0_0_0_10_1_0_0_0, "st_exec");
    mem_ready = 1'b0;
    #2;
    check(11'b0_1_0_0_0_10_0_0_0_0, "st_mem_wait");
    #1;
    reset = 1'b1;
    #1;
    check(O_IDLE, "st_rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check(O_FETCH, "st_after_rst");
    @(posedge clk);
    #1;

    // Load whose data never arrives: ERR after 4 MEM wait cycles, sticky.
    step(0, OP_LOAD, 1, 0, O_IR, "ldto_fetch");
    step(0, 7'd0, 1, 0, 11'b0_0_0_0_0_01_0_0_0_0, "ldto_decode");
    step(0, 7'd0, 0, 0, 11'b0_0_0_0_0_01_1_0_0_0, "ldto_exec");
    for (int i = 0; i < 4; i++)
      step(0, 7'd0, 0, 0, 11'b1_0_0_0_0_01_0_0_0_0, $sformatf("ldto_mem%0d", i));
    step(0, 7'd0, 1, 0, O_ERR, "ldto_err");
    step(0, OP_LOAD, 1, 0, O_ERR, "ldto_err_sticky");
    step(1, 7'd0, 0, 0, O_IDLE, "ldto_reset");
    step(0, OP_RTYPE, 1, 0, O_IR, "ldto_refetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
